// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
// Each cycle one DIGIT-bit slice of the operands is added. The carry between
// slices is registered, so a WIDTH-bit operation takes WIDTH/DIGIT cycles.
// Flags (carry/borrow, signed overflow, zero, negative) are registered on
// entry to DONE. They are held stable until the consumer takes the result.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overf,
  output logic             zerof,
  output logic             negf
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter combinations the slicing scheme cannot handle.
  if (WIDTH < 2) begin : g_bad_width
    $error("addsub_seq: WIDTH must be at least 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("addsub_seq: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDXW-1:0]   idx_r;
  logic              carry_r;
  logic              op_r;
  logic [WIDTH-1:0]  opa_r;
  logic [WIDTH-1:0]  opb_r;
  logic [WIDTH-1:0]  result_r;
  logic              cout_r;
  logic              overf_r;
  logic              zerof_r;
  logic              negf_r;
  logic              out_valid_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              last_s;
  logic [DIGIT-1:0]  a_sl_s;
  logic [DIGIT-1:0]  b_sl_s;
  logic [DIGIT:0]    sum_s;
  logic              c_msb_in_s;
  logic [WIDTH-1:0]  result_nxt_s;

  // Handshake decode: ready in IDLE, or in DONE when the result is being taken.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else if ((state_r == DONE) && out_ready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = in_valid && in_ready_s;
  assign last_s   = (idx_r == IDXW'(N - 1));

  // Slice adder. The carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    a_sl_s       = opa_r[int'(idx_r) * DIGIT +: DIGIT];
    b_sl_s       = opb_r[int'(idx_r) * DIGIT +: DIGIT];
    sum_s        = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{DIGIT{1'b0}}, carry_r};
    c_msb_in_s   = sum_s[DIGIT-1] ^ a_sl_s[DIGIT-1] ^ b_sl_s[DIGIT-1];
    result_nxt_s = result_r;
    result_nxt_s[int'(idx_r) * DIGIT +: DIGIT] = sum_s[DIGIT-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. DONE can re-accept directly into BUSY.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready && in_valid) begin
          state_nxt_s = BUSY;
        end else if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath. Latch operands on accept, then add one slice per BUSY cycle.
  // Flags are captured together with the top slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= {IDXW{1'b0}};
      carry_r     <= 1'b0;
      op_r        <= 1'b0;
      opa_r       <= {WIDTH{1'b0}};
      opb_r       <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      overf_r     <= 1'b0;
      zerof_r     <= 1'b0;
      negf_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        opa_r   <= a;
        opb_r   <= op ? ~b : b;
        carry_r <= op;
        op_r    <= op;
        idx_r   <= {IDXW{1'b0}};
      end else if (state_r == BUSY) begin
        result_r <= result_nxt_s;
        carry_r  <= sum_s[DIGIT];
        idx_r    <= idx_r + IDXW'(1);
        if (last_s) begin
          cout_r  <= sum_s[DIGIT] ^ op_r;
          overf_r <= sum_s[DIGIT] ^ c_msb_in_s;
          zerof_r <= (result_nxt_s == {WIDTH{1'b0}});
          negf_r  <= result_nxt_s[WIDTH-1];
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign overf     = overf_r;
  assign zerof     = zerof_r;
  assign negf      = negf_r;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed testbench for addsub_seq.
// It drives three instances: 32/8 (sel 0), 16/16 (sel 1) and 16/4 (sel 2).
// The instances share their inputs, except in_valid, which goes to the
// selected instance only.
module tb_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic        op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        out_ready;
  int          cur_sel;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] res0;
  logic [15:0] res1, res2;
  logic [3:0]  fl0, fl1, fl2;

  logic        in_ready_m;
  logic        out_valid_m;
  logic [31:0] result_m;
  logic [3:0]  flags_m;

  int n_checks;
  int n_errors;

  addsub_seq #(.WIDTH(32), .DIGIT(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy0), .op(op_s),
    .a(a_s), .b(b_s), .out_valid(ov0), .out_ready(out_ready), .result(res0),
    .cout(fl0[3]), .overf(fl0[2]), .zerof(fl0[1]), .negf(fl0[0])
  );

  addsub_seq #(.WIDTH(16), .DIGIT(16)) u_dut16a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy1), .op(op_s),
    .a(a_s[15:0]), .b(b_s[15:0]), .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .cout(fl1[3]), .overf(fl1[2]), .zerof(fl1[1]), .negf(fl1[0])
  );

  addsub_seq #(.WIDTH(16), .DIGIT(4)) u_dut16b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy2), .op(op_s),
    .a(a_s[15:0]), .b(b_s[15:0]), .out_valid(ov2), .out_ready(out_ready), .result(res2),
    .cout(fl2[3]), .overf(fl2[2]), .zerof(fl2[1]), .negf(fl2[0])
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    in_ready_m  = rdy0;
    out_valid_m = ov0;
    result_m    = res0;
    flags_m     = fl0;
    case (cur_sel)
      1: begin
        in_ready_m = rdy1; out_valid_m = ov1; result_m = {16'h0000, res1}; flags_m = fl1;
      end
      2: begin
        in_ready_m = rdy2; out_valid_m = ov2; result_m = {16'h0000, res2}; flags_m = fl2;
      end
      default: begin
        in_ready_m = rdy0; out_valid_m = ov0; result_m = res0; flags_m = fl0;
      end
    endcase
  end

  // Single comparison point; counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full operation on instance sel: accept, latency, result, flags, release.
  task automatic do_op(input int sel, input int nexp, input logic opv,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic [3:0] ef, input string tag);
    int lat;
    @(negedge clk);
    cur_sel   = sel;
    op_s      = opv;
    a_s       = av;
    b_s       = bv;
    out_ready = 1'b0;
    iv        = 3'b000;
    iv[sel]   = 1'b1;
    #1;
    check_val({tag, ".in_ready"}, {31'd0, in_ready_m}, 32'd1);
    @(negedge clk);
    iv  = 3'b000;
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, ".latency"}, 32'(lat), 32'(nexp));
    check_val({tag, ".result"}, result_m, er);
    check_val({tag, ".flags"}, {28'd0, flags_m}, {28'd0, ef});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, ".idle_valid"}, {31'd0, out_valid_m}, 32'd0);
  endtask

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Directed test sequence.
  initial begin
    int lat;
    n_checks  = 0;
    n_errors  = 0;
    cur_sel   = 0;
    rst_n     = 1'b0;
    iv        = 3'b000;
    op_s      = 1'b0;
    a_s       = 32'd0;
    b_s       = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("reset.in_ready", {31'd0, in_ready_m}, 32'd1);
    check_val("reset.out_valid", {31'd0, out_valid_m}, 32'd0);
    check_val("reset.result", result_m, 32'd0);
    check_val("reset.flags", {28'd0, flags_m}, 32'd0);

    // 32-bit vectors, flags are {cout, overf, zerof, negf}.
    do_op(0, 4, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 4'b0000, "add_ff_1");
    do_op(0, 4, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, "add_ovf");
    do_op(0, 4, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, "add_wrap");
    do_op(0, 4, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0010, "sub_5_5");
    do_op(0, 4, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1001, "sub_0_1");
    do_op(0, 4, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0100, "sub_ovf");
    do_op(0, 4, 1'b1, 32'h12345678, 32'h01234567, 32'h11111111, 4'b0000, "sub_mix");

    // Backpressure: hold DONE for 3 cycles, then re-accept on the release edge.
    @(negedge clk);
    cur_sel = 0; op_s = 1'b0; a_s = 32'd10; b_s = 32'd20; out_ready = 1'b0; iv = 3'b001;
    @(negedge clk);
    iv  = 3'b000;
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("bp.latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check_val("bp.hold_valid", {31'd0, out_valid_m}, 32'd1);
      check_val("bp.hold_ready", {31'd0, in_ready_m}, 32'd0);
      check_val("bp.hold_result", result_m, 32'd30);
      check_val("bp.hold_flags", {28'd0, flags_m}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; iv = 3'b001; a_s = 32'd3; b_s = 32'd4;
    #1;
    check_val("bp.release_ready", {31'd0, in_ready_m}, 32'd1);
    @(negedge clk);
    check_val("bp.valid_drop", {31'd0, out_valid_m}, 32'd0);
    a_s = 32'd10; b_s = 32'd1;
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("bp.stream_latency", 32'(lat), 32'd4);
    check_val("bp.stream_result", result_m, 32'd7);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid_m && lat < 40);
    check_val("bp.stream_period", 32'(lat), 32'd5);
    check_val("bp.stream_result2", result_m, 32'd11);
    iv = 3'b000;
    @(negedge clk);
    check_val("bp.to_idle", {31'd0, out_valid_m}, 32'd0);
    out_ready = 1'b0;

    // Reset in BUSY while idx is 2.
    @(negedge clk);
    cur_sel = 0; op_s = 1'b0; a_s = 32'h11111111; b_s = 32'h11111111; iv = 3'b001;
    @(negedge clk);
    iv = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst.out_valid", {31'd0, out_valid_m}, 32'd0);
    check_val("rst.result", result_m, 32'd0);
    check_val("rst.flags", {28'd0, flags_m}, 32'd0);
    check_val("rst.in_ready", {31'd0, in_ready_m}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst.after_ready", {31'd0, in_ready_m}, 32'd1);
    check_val("rst.after_valid", {31'd0, out_valid_m}, 32'd0);
    do_op(0, 4, 1'b0, 32'd2, 32'd3, 32'd5, 4'b0000, "rst_add");

    // 16-bit instances: single-slice (latency 1) and four-slice (latency 4).
    for (int s = 1; s <= 2; s++) begin
      int nl;
      nl = (s == 1) ? 1 : 4;
      do_op(s, nl, 1'b0, 32'h00007FFF, 32'h00000001, 32'h00008000, 4'b0101, $sformatf("w16_%0d.add_ovf", s));
      do_op(s, nl, 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00000000, 4'b1010, $sformatf("w16_%0d.add_wrap", s));
      do_op(s, nl, 1'b1, 32'h00008000, 32'h00000001, 32'h00007FFF, 4'b0100, $sformatf("w16_%0d.sub_ovf", s));
      do_op(s, nl, 1'b1, 32'h00000000, 32'h00000001, 32'h0000FFFF, 4'b1001, $sformatf("w16_%0d.sub_0_1", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes on both sides. Each cycle it processes one DIGIT-bit slice of the operands and carries the result forward in a registered carry, so a WIDTH-bit operation completes in WIDTH/DIGIT cycles. It reports carry/borrow, signed overflow, zero and negative flags. It is the datapath arithmetic unit that the ALU control issues add/sub operations to, and it replaces the fixed 32-bit combinational ripple adder and subtractor pair.

## Interface

Parameters:
- WIDTH, default 32: operand and result width. Must be ≥ 2.
- DIGIT, default 8: bits processed per cycle. WIDTH % DIGIT == 0 is required; elaboration fails otherwise. N = WIDTH/DIGIT.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: an operation is presented on op/a/b.
- in_ready, output, 1: the unit accepts an operation this cycle.
- op, input, 1: 0 = add (a+b), 1 = subtract (a−b).
- a, input, WIDTH: first operand.
- b, input, WIDTH: second operand.
- out_valid, output, 1: result and flags are valid.
- out_ready, input, 1: the consumer takes the result this cycle.
- result, output, WIDTH: sum or difference, modulo 2^WIDTH.
- cout, output, 1: on add, carry out of the MSB; on subtract, borrow (1 when a < b unsigned).
- overf, output, 1: signed overflow.
- zerof, output, 1: result == 0. This flag is independent of overf.
- negf, output, 1: result[WIDTH-1].

## Operation

- FSM states: IDLE, BUSY, DONE.
- An operation is accepted on any edge where in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready and never depends on in_valid.
- On accept:
  - latch a into opa;
  - latch b into opb when op=0, or ~b when op=1;
  - set carry = op, so subtraction computes a + ~b + 1;
  - latch op; clear the slice counter idx to 0; go to BUSY.
- BUSY, each cycle:
  - {c, s} = opa[idx slice] + opb[idx slice] + carry;
  - write s into result_reg[idx slice]; carry ← c;
  - for the top slice, also record the carry into bit WIDTH-1 as c_msb_in;
  - idx increments; after slice N−1, go to DONE.
- Entering DONE registers the flags:
  - cout = carry XOR op_latched;
  - overf = carry XOR c_msb_in;
  - zerof = (result == 0), using the full final value;
  - negf = result MSB.
- In DONE, out_valid=1 and result and flags are held stable while out_ready=0.
- DONE with out_ready=1 and in_valid=1: the new operation is accepted on the same edge and the state goes directly to BUSY. out_valid drops for the new computation.
- DONE with out_ready=1 and in_valid=0: go to IDLE.
- Inputs a, b and op are ignored except on the accept edge. They may change freely during BUSY.
- Reset (asynchronous, at any time including mid-BUSY) aborts any in-flight operation with no output:
  - state=IDLE, idx=0, carry=0;
  - result=0, cout=0, overf=0, zerof=0, negf=0;
  - out_valid=0, so in_ready=1.
- While in IDLE and BUSY, result and flags hold their previous or partially written values and are undefined for the consumer; only out_valid qualifies them.

## Timing

- Latency: for an accept at edge k, out_valid rises after edge k+N.
- With DIGIT=WIDTH (N=1), latency is 1 cycle.
- Sustained throughput is one operation per N+1 cycles when out_ready is held high and in_valid is continuously asserted.
- The carry between slices is registered, so the combinational path is a DIGIT-bit add plus the flag logic.
- out_valid is registered and has no combinational path from in_valid.

## Test plan

- Add 0x000000FF + 0x00000001 (WIDTH=32, DIGIT=8). Required: result 0x00000100, cout=0, overf=0, zerof=0, negf=0, out_valid exactly 4 cycles after accept. This checks carry propagation across a slice boundary.
- Add 0x7FFFFFFF + 1 → 0x80000000, overf=1, negf=1, cout=0. Add 0xFFFFFFFF + 1 → 0x00000000, cout=1, overf=0, zerof=1.
- Subtract 5 − 5 → 0, zerof=1, cout=0. Subtract 0 − 1 → 0xFFFFFFFF, cout=1 (borrow), negf=1, overf=0. Subtract 0x80000000 − 1 → 0x7FFFFFFF, overf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE. Required: result and flags stable, in_ready=0. Then raise out_ready with in_valid=1 (3 + 4). Required: accepted on that edge, next out_valid with result 7 four cycles later, 5-cycle issue period under continuous streaming.
- Assert rst_n=0 for 1 cycle when idx=2 in BUSY. Required: immediately out_valid=0 and all outputs 0. After release in_ready=1, and a new add 2 + 3 returns 5 after 4 cycles.
- Re-elaborate with WIDTH=16, DIGIT=16 and with WIDTH=16, DIGIT=4; repeat the overflow vectors scaled to 16 bits. Required: latency 1 and 4 cycles respectively, with identical results and flags.
